// File: rtl/micro_seq_if.sv
// Programming bus for micro_seq: a single write strobe with table select, address and data.
interface micro_seq_if #(
  parameter int STATE_W = 4
);
  logic                 prog_we;
  logic [2:0]           prog_sel;
  logic [STATE_W-1:0]   prog_addr;
  logic [STATE_W+2:0]   prog_data;

  modport master (
    output prog_we,
    output prog_sel,
    output prog_addr,
    output prog_data
  );

  modport slave (
    input prog_we,
    input prog_sel,
    input prog_addr,
    input prog_data
  );
endinterface

// File: rtl/micro_seq.sv
// micro_seq: microcoded next-state sequencer with run-time writable microcode and dispatch tables.
// Optional MSEQ_EDGE_ADV_EN: any change of the synchronised holder input also advances the state.
module micro_seq #(
  parameter int STATE_W  = 4,
  parameter int IN_W     = 2,
  parameter int NUM_DTAB = 2,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_W-1:0]     holder,
  input  logic                run,
  micro_seq_if.slave          prog,
  output logic [STATE_W-1:0]  state,
  output logic                step,
  output logic [31:0]         tick_cnt
);

  localparam int DEPTH  = 2 ** STATE_W;
  localparam int DDEPTH = 2 ** IN_W;
  localparam int WORD_W = STATE_W + 3;
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_DISP = 3'd1,
    OP_JUMP = 3'd2,
    OP_HOLD = 3'd3,
    OP_ZERO = 3'd4
  } op_e;

  logic [WORD_W-1:0]  mrom_q [DEPTH];
  logic [WORD_W-1:0]  mrom_d [DEPTH];
  logic [STATE_W-1:0] dtab_q [NUM_DTAB][DDEPTH];
  logic [STATE_W-1:0] dtab_d [NUM_DTAB][DDEPTH];

  logic [STATE_W-1:0] state_q, state_d;
  logic               step_q, step_d;
  logic [31:0]        tick_cnt_q, tick_cnt_d;
  logic [IN_W-1:0]    sync1_q, sync1_d;
  logic [IN_W-1:0]    hs_q, hs_d;

  logic [WORD_W-1:0]  word;
  op_e                op;
  logic [STATE_W-1:0] arg;
  logic [STATE_W-1:0] disp_state;
  logic [STATE_W-1:0] next_state;
  logic               tick;
  logic               change;
  logic               advance;

`ifdef MSEQ_EDGE_ADV_EN
  logic [IN_W-1:0]    prev_hs_q, prev_hs_d;

  always_comb begin
    prev_hs_d = hs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_hs_q <= '0;
    end else begin
      prev_hs_q <= prev_hs_d;
    end
  end

  assign change = (hs_q != prev_hs_q);
`else
  assign change = 1'b0;
`endif

  // Decode the current microcode word; an unimplemented dispatch table yields state 0.
  always_comb begin
    word       = mrom_q[state_q];
    op         = op_e'(word[WORD_W-1:STATE_W]);
    arg        = word[STATE_W-1:0];
    disp_state = '0;
    for (int k = 0; k < NUM_DTAB; k++) begin
      if (arg[1:0] == 2'(k)) begin
        disp_state = dtab_q[k][hs_q];
      end
    end
    case (op)
      OP_SEQ:  next_state = state_q + 1'b1;
      OP_DISP: next_state = disp_state;
      OP_JUMP: next_state = arg;
      OP_HOLD: next_state = state_q;
      default: next_state = '0;
    endcase
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    advance    = run & (tick | change);
    sync1_d    = holder;
    hs_d       = sync1_q;
    step_d     = advance;
    state_d    = advance ? next_state : state_q;
    tick_cnt_d = tick_cnt_q;
    if (run) begin
      tick_cnt_d = advance ? 32'd0 : tick_cnt_q + 32'd1;
    end
  end

  // Writes land at the edge, so an advance in the same cycle still reads the old word.
  always_comb begin
    mrom_d = mrom_q;
    dtab_d = dtab_q;
    if (prog.prog_we) begin
      if (prog.prog_sel == 3'd0) begin
        mrom_d[prog.prog_addr] = prog.prog_data;
      end
      for (int k = 0; k < NUM_DTAB; k++) begin
        if (prog.prog_sel == 3'(k + 1)) begin
          dtab_d[k][prog.prog_addr[IN_W-1:0]] = prog.prog_data[STATE_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= '0;
      step_q     <= 1'b0;
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      hs_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mrom_q[i] <= '0;
      end
      for (int k = 0; k < NUM_DTAB; k++) begin
        for (int j = 0; j < DDEPTH; j++) begin
          dtab_q[k][j] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      hs_q       <= hs_d;
      mrom_q     <= mrom_d;
      dtab_q     <= dtab_d;
    end
  end

  assign state    = state_q;
  assign step     = step_q;
  assign tick_cnt = tick_cnt_q;

endmodule
